irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller between the interrupt sources (TC0 IRQ, TC1 IRQ, external interrupt) and the CPU.
//  It latches requests, masks them, picks the highest-priority one, and sequences an ACK/EOI handshake.
//  The result is one request line plus a vector for CP0.
//  The block is mapped as a bridge peripheral with 4 word registers, accessed like a TC.
// PARAMETERS
//  N_SRC     3      number of sources, 1..32; bit 0 = highest priority
//  MODE_RST  3'b000 reset value of MODE; 1 = rising-edge source, 0 = level source
// PORTS
//  clk      in   1      system clock; all state changes on posedge
//  reset    in   1      synchronous, active-low reset
//  addr     in   32     bridge address; only addr[3:2] is decoded (0 PEND, 1 MASK, 2 MODE, 3 VEC)
//  we       in   1      write strobe, already qualified by the bridge
//  din      in   32     write data
//  dout     out  32     read data; combinational from addr[3:2] and current registers
//  irq_src  in   N_SRC  raw source lines; synchronous to clk
//  irq      out  1      request to CPU; registered
//  vector   out  5      index of the highest-priority masked-pending source; valid while irq=1
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - PEND=0, MASK=0, MODE=MODE_RST, prev=0, isr_idx=0, state=IDLE, irq=0; vector output 0.
//  Source sampling, every cycle:
//   - Level source: PEND[i] <= irq_src[i]. W1C writes have no effect on it.
//   - Edge source: PEND[i] is set when irq_src[i]=1 and prev[i]=0; prev <= irq_src.
//  PEND write (offset 0): write-1-to-clear on edge bits. If a set and a clear hit in the same cycle, the set wins.
//  MASK and MODE (offsets 1, 2): read/write on bits [N_SRC-1:0]; upper bits read 0.
//  Changing MODE from edge to level: the bit follows the level from the next cycle.
//  act = PEND & MASK; cur_vec = lowest set index of act (0 when act==0).
//  VEC read value: bits [4:0]=cur_vec, bit 8=|act, bits [20:16]=isr_idx, bits [31:30]=state, other bits 0.
//  FSM (state encoding IDLE=0, PENDING=1, INSERVICE=2); irq is 1 only in PENDING:
//   - IDLE: if |act, go to PENDING on the next edge, so irq rises 1 cycle after the source is seen in PEND.
//   - PENDING, if act==0 (masked or cleared): go to IDLE and drop irq.
//   - PENDING, on ACK (we, offset 3, din[31]=0): isr_idx <= cur_vec; clear that PEND bit if it is an edge source; go to INSERVICE.
//   - INSERVICE: irq=0; new requests only accumulate in PEND; no nesting.
//   - INSERVICE, on EOI (we, offset 3, din[31]=1): go to IDLE; a remaining act re-raises irq one cycle later.
//  Decisions use pre-write register values. An ACK that coincides with an edge set on the same bit leaves PEND=1.
//  Writes and their effects:
//   - ACK in IDLE or INSERVICE is ignored.
//   - EOI outside INSERVICE is ignored.
//   - Writes to offset 3 modify no register other than isr_idx and state.
//   - Reads have no side effects.
//  Reset asserted mid-handshake returns to IDLE with all registers at their reset values; a pending EOI is lost.
//  N_SRC < 32: irq_src and registers are zero-extended in dout; indices >= N_SRC never appear.
// TESTING
//  1. Reset (reset=0, 2 cycles) -> irq=0; PEND, MASK and MODE read 0; VEC reads 0.
//  2. MASK=3'b111, MODE=0, pulse irq_src[1] for 1 cycle:
//     -> PEND=3'b010 for 1 cycle; irq is high for 1 cycle; state returns to IDLE.
//  3. MODE=3'b011, MASK=3'b011, single-cycle pulse on irq_src[1]:
//     -> PEND[1] stays set; irq=1, vector=1.
//     -> ACK -> next cycle irq=0, PEND=0, VEC[20:16]=1, state=2.
//     -> EOI -> state=0.
//  4. Edges on sources 0 and 1 in the same cycle, MODE=3'b011, MASK=3'b011:
//     -> vector=0; ACK, then EOI -> irq returns 1 cycle after EOI with vector=1.
//  5. Source 2 pending with MASK=0 -> irq stays 0; write MASK=3'b100 -> irq=1 one cycle later.
//     Write MASK=0 while PENDING -> irq=0 and state=IDLE the next cycle.
//  6. Mid-INSERVICE reset -> state=0, irq=0; spurious ACK in IDLE and EOI in PENDING leave all registers unchanged.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches, masks and prioritises interrupt sources and runs an ACK/EOI handshake to the CPU
// Ports:
//   clk_i       system clock, all state changes on posedge
//   rst_ni      synchronous active-low reset
//   addr_i      bridge address, only [3:2] decoded (0 PEND, 1 MASK, 2 MODE, 3 VEC)
//   we_i        qualified write strobe
//   din_i       write data
//   dout_o      read data, combinational from addr_i[3:2]
//   irq_src_i   raw source lines, synchronous to clk_i
//   irq_o       registered request to the CPU, high only in PENDING
//   vector_o    index of the highest-priority masked-pending source
module irq_ctrl #(
    parameter int               N_SRC    = 3,
    parameter logic [N_SRC-1:0] MODE_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [31:0]      din_i,
    output logic [31:0]      dout_o,
    input  logic [N_SRC-1:0] irq_src_i,
    output logic             irq_o,
    output logic [4:0]       vector_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, INSERVICE = 2'd2} state_t;
    state_t           state_q;
    logic [N_SRC-1:0] pend_q, pend_d, mask_q, mode_q, prev_q, act;
    logic [4:0]       isr_idx_q, cur_vec;
    logic [1:0]       off;
    logic             any_act, wr_pend, wr_mask, wr_mode, wr_vec, ack, eoi, irq_q;
    logic             unused_bits;
    assign unused_bits = ^{addr_i, din_i};
    assign off     = addr_i[3:2];
    assign act     = pend_q & mask_q;
    assign any_act = |act;
    assign wr_pend = we_i && off == 2'd0;
    assign wr_mask = we_i && off == 2'd1;
    assign wr_mode = we_i && off == 2'd2;
    assign wr_vec  = we_i && off == 2'd3;
    // An ACK only counts while there is still something to acknowledge
    assign ack     = wr_vec && !din_i[31] && state_q == PENDING && any_act;
    assign eoi     = wr_vec && din_i[31] && state_q == INSERVICE;
    assign irq_o    = irq_q;
    assign vector_o = cur_vec;
    always_comb begin
        cur_vec = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (act[i]) cur_vec = 5'(i);
    end
    // Edge bits: a fresh edge beats a W1C or ACK clear in the same cycle
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++)
            pend_d[i] = mode_q[i]
                ? (irq_src_i[i] && !prev_q[i]) ||
                  (pend_q[i] && !((wr_pend && din_i[i]) || (ack && cur_vec == 5'(i))))
                : irq_src_i[i];
    end
    always_comb begin
        dout_o = off == 2'd0 ? 32'(pend_q) :
                 off == 2'd1 ? 32'(mask_q) :
                 off == 2'd2 ? 32'(mode_q) :
                 {state_q, 9'b0, isr_idx_q, 7'b0, any_act, 3'b0, cur_vec};
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_q    <= '0;
            mask_q    <= '0;
            mode_q    <= MODE_RST;
            prev_q    <= '0;
            isr_idx_q <= '0;
            state_q   <= IDLE;
            irq_q     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            prev_q <= irq_src_i;
            if (wr_mask) mask_q <= din_i[N_SRC-1:0];
            if (wr_mode) mode_q <= din_i[N_SRC-1:0];
            case (state_q)
                IDLE: if (any_act) begin
                    state_q <= PENDING;
                    irq_q   <= 1'b1;
                end
                PENDING: if (!any_act) begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end else if (ack) begin
                    state_q   <= INSERVICE;
                    isr_idx_q <= cur_vec;
                    irq_q     <= 1'b0;
                end
                INSERVICE: if (eoi) state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
